decode_operand_forward_unit: RTL and testbench
==============================================

Name: decode_operand_forward_unit

Overview:
- Parametrised successor to the decode-stage register-read bypass mux.
- Supplies NUM_READ_PORTS decode operands, each resolved by youngest-first forwarding from execute, memory and writeback.
- Detects load-use hazards and holds decode in a stall FSM until the load's data is valid in memory, with a timeout watchdog.
- Sits between the register file read ports and the decode/execute pipeline register.

Parameters:
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_WIDTH, 4, register index width
- NUM_READ_PORTS, 2, decode source operands per cycle
- OPCODE_WIDTH, 8, opcode width (NOP=0, LW=1, SW=2, ADD=3, SUB=4)
- ZERO_REG, 1, when 1 register 0 reads as zero and never forwards or hazards
- TIMEOUT_CYCLES, 15, maximum cycles in WAIT_LOAD before abort (>=1)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous pipeline flush
- i_rs  in  NUM_READ_PORTS*REG_ADDR_WIDTH  source register per port; port k occupies bits [k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
- i_rs_used  in  NUM_READ_PORTS  port k is a real operand
- i_rd  in  NUM_READ_PORTS*DATA_WIDTH  register file read data per port
- i_execute_opcode / i_execute_ws / i_execute_data  in  OPCODE_WIDTH / REG_ADDR_WIDTH / DATA_WIDTH  execute stage
- i_memory_opcode / i_memory_ws / i_memory_data  in  same widths  memory stage
- i_memory_valid  in  1  i_memory_data holds final load data
- i_writeback_we / i_writeback_ws / i_writeback_data  in  1 / REG_ADDR_WIDTH / DATA_WIDTH  writeback stage
- o_rd  out  NUM_READ_PORTS*DATA_WIDTH  resolved operands
- o_fwd_sel  out  2*NUM_READ_PORTS  per port: 0=regfile, 1=execute, 2=memory, 3=writeback
- o_stall  out  1  freeze fetch/decode and insert an execute bubble
- o_timeout  out  1  sticky: a load wait was aborted

Behaviour:
- Forwarding (combinational, per port k, highest priority first):
  - ZERO_REG=1 and rs==0 -> 0, sel 0.
  - Execute opcode ADD/SUB and ws==rs -> execute data, sel 1.
  - Memory opcode ADD/SUB, or opcode LW with i_memory_valid, and ws==rs -> memory data, sel 2.
  - i_writeback_we and ws==rs -> writeback data, sel 3.
  - Otherwise i_rd, sel 0.
  - Execute LW never forwards; memory LW without valid never forwards.
  - Unused ports (i_rs_used=0) still compute o_rd but never cause hazards.
- hazard = any used port whose rs matches i_execute_ws with execute opcode LW, excluding reg 0 when ZERO_REG=1.
- FSM states IDLE, WAIT_LOAD. Registers: r_pending_ws and r_count, width clog2(TIMEOUT_CYCLES+1).
- IDLE:
  - o_stall = hazard.
  - On hazard: latch i_execute_ws into r_pending_ws, clear r_count, go WAIT_LOAD.
- WAIT_LOAD:
  - release = i_memory_opcode==LW && i_memory_ws==r_pending_ws && i_memory_valid.
  - o_stall = !release && r_count!=TIMEOUT_CYCLES.
  - On release: return IDLE the same cycle; operands take memory data via normal forwarding.
  - No release and r_count==TIMEOUT_CYCLES: set o_timeout, return IDLE, o_stall low that cycle.
  - Otherwise r_count increments.
  - A new hazard is not evaluated in WAIT_LOAD; it is re-evaluated in IDLE next cycle.
- i_flush has priority over all transitions: next state IDLE, r_count cleared, o_stall forced 0 that cycle. o_timeout is unaffected.
- Reset: state IDLE, r_pending_ws=0, r_count=0, o_timeout=0. Reset asserted mid-stall drops o_stall at once, because o_stall is derived from state.
- Latency: forwarding is 0 cycles. Minimum stall is 1 cycle (load valid on the first memory cycle).
- o_timeout clears only on reset.

Test Plan:
- Port0 rs=3, execute ADD ws=3 data=0x11, memory ADD ws=3 data=0x22 -> o_rd[0]=0x11, sel=1, o_stall=0.
- rs=5, execute LW ws=5 -> o_stall=1 cycle 0. Next cycle memory LW ws=5 valid data=0xCAFE -> o_stall=0, o_rd=0xCAFE, sel=2, FSM IDLE.
- Same as above but i_memory_valid low for 3 cycles -> o_stall high 4 cycles total, released on the valid cycle.
- Memory valid never arrives, TIMEOUT_CYCLES=15 -> o_stall high 16 cycles, then low with o_timeout=1, which stays set.
- rs=0, ZERO_REG=1, execute LW ws=0, writeback we ws=0 data=0x7 -> o_rd=0, no stall. Port1 rs=9 with i_rs_used=0 matching an execute LW -> no stall.
- Assert i_flush mid-WAIT_LOAD -> o_stall=0 the same cycle, IDLE next. Then assert i_reset_n=0 mid-stall -> o_stall drops asynchronously and o_timeout=0.

Source files
------------

// File: rtl/decode_operand_forward_unit_if.sv
// Decode operand bus: register-read request, pipeline stage taps and the resolved
// operands / stall status returned to decode.
interface decode_operand_forward_unit_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned NUM_READ_PORTS = 2,
    parameter int unsigned OPCODE_WIDTH   = 8
);
    logic                                     i_flush;
    logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] i_rs;
    logic [NUM_READ_PORTS-1:0]                i_rs_used;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     i_rd;

    logic [OPCODE_WIDTH-1:0]                  i_execute_opcode;
    logic [REG_ADDR_WIDTH-1:0]                i_execute_ws;
    logic [DATA_WIDTH-1:0]                    i_execute_data;

    logic [OPCODE_WIDTH-1:0]                  i_memory_opcode;
    logic [REG_ADDR_WIDTH-1:0]                i_memory_ws;
    logic [DATA_WIDTH-1:0]                    i_memory_data;
    logic                                     i_memory_valid;

    logic                                     i_writeback_we;
    logic [REG_ADDR_WIDTH-1:0]                i_writeback_ws;
    logic [DATA_WIDTH-1:0]                    i_writeback_data;

    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     o_rd;
    logic [2*NUM_READ_PORTS-1:0]              o_fwd_sel;
    logic                                     o_stall;
    logic                                     o_timeout;

    modport master (
        output i_flush, i_rs, i_rs_used, i_rd,
        output i_execute_opcode, i_execute_ws, i_execute_data,
        output i_memory_opcode, i_memory_ws, i_memory_data, i_memory_valid,
        output i_writeback_we, i_writeback_ws, i_writeback_data,
        input  o_rd, o_fwd_sel, o_stall, o_timeout
    );

    modport slave (
        input  i_flush, i_rs, i_rs_used, i_rd,
        input  i_execute_opcode, i_execute_ws, i_execute_data,
        input  i_memory_opcode, i_memory_ws, i_memory_data, i_memory_valid,
        input  i_writeback_we, i_writeback_ws, i_writeback_data,
        output o_rd, o_fwd_sel, o_stall, o_timeout
    );
endinterface

// File: rtl/decode_operand_forward_unit.sv
// Decode-stage operand bypass: youngest-first forwarding from execute/memory/writeback
// plus a load-use stall FSM with a timeout watchdog.
module decode_operand_forward_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned NUM_READ_PORTS = 2,
    parameter int unsigned OPCODE_WIDTH   = 8,
    parameter bit          ZERO_REG       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic i_clk,
    input logic i_reset_n,
    decode_operand_forward_unit_if.slave bus
);
    localparam int unsigned COUNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [OPCODE_WIDTH-1:0] OP_LW  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    state_t                    state;
    logic [REG_ADDR_WIDTH-1:0] r_pending_ws;
    logic [COUNT_W-1:0]        r_count;
    logic                      r_timeout;

    logic                                 exe_fwd_ok;
    logic                                 exe_is_lw;
    logic                                 mem_fwd_ok;
    logic                                 hazard;
    logic                                 load_release;
    logic                                 count_max;
    logic                                 stall;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] fwd_rd;
    logic [2*NUM_READ_PORTS-1:0]          fwd_sel;

    assign exe_fwd_ok = (bus.i_execute_opcode == OP_ADD) || (bus.i_execute_opcode == OP_SUB);
    assign exe_is_lw  = (bus.i_execute_opcode == OP_LW);
    assign mem_fwd_ok = (bus.i_memory_opcode == OP_ADD) || (bus.i_memory_opcode == OP_SUB) ||
                        ((bus.i_memory_opcode == OP_LW) && bus.i_memory_valid);

    // Per-port priority: zero register, then youngest producing stage first.
    always_comb begin
        logic [REG_ADDR_WIDTH-1:0] rs_k;
        fwd_rd  = '0;
        fwd_sel = '0;
        hazard  = 1'b0;
        for (int unsigned k = 0; k < NUM_READ_PORTS; k++) begin
            rs_k = bus.i_rs[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            if (ZERO_REG && (rs_k == '0)) begin
                fwd_rd[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                fwd_sel[2*k +: 2]                  = 2'd0;
            end else if (exe_fwd_ok && (bus.i_execute_ws == rs_k)) begin
                fwd_rd[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_execute_data;
                fwd_sel[2*k +: 2]                  = 2'd1;
            end else if (mem_fwd_ok && (bus.i_memory_ws == rs_k)) begin
                fwd_rd[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_memory_data;
                fwd_sel[2*k +: 2]                  = 2'd2;
            end else if (bus.i_writeback_we && (bus.i_writeback_ws == rs_k)) begin
                fwd_rd[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_writeback_data;
                fwd_sel[2*k +: 2]                  = 2'd3;
            end else begin
                fwd_rd[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_rd[k*DATA_WIDTH +: DATA_WIDTH];
                fwd_sel[2*k +: 2]                  = 2'd0;
            end

            if (bus.i_rs_used[k] && exe_is_lw && (bus.i_execute_ws == rs_k) &&
                !(ZERO_REG && (rs_k == '0))) begin
                hazard = 1'b1;
            end
        end
    end

    assign load_release = (bus.i_memory_opcode == OP_LW) &&
                          (bus.i_memory_ws == r_pending_ws) && bus.i_memory_valid;
    assign count_max    = (r_count == COUNT_W'(TIMEOUT_CYCLES));

    // Stall is decoded from state so an asynchronous reset drops it immediately.
    always_comb begin
        stall = 1'b0;
        if (!bus.i_flush) begin
            case (state)
                IDLE:      stall = hazard;
                WAIT_LOAD: stall = !load_release && !count_max;
                default:   stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            r_pending_ws <= '0;
            r_count      <= '0;
            r_timeout    <= 1'b0;
        end else if (bus.i_flush) begin
            state   <= IDLE;
            r_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard) begin
                        r_pending_ws <= bus.i_execute_ws;
                        r_count      <= '0;
                        state        <= WAIT_LOAD;
                    end
                end
                WAIT_LOAD: begin
                    if (load_release) begin
                        state <= IDLE;
                    end else if (count_max) begin
                        r_timeout <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        r_count <= r_count + COUNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_rd      = fwd_rd;
    assign bus.o_fwd_sel = fwd_sel;
    assign bus.o_stall   = stall;
    assign bus.o_timeout = r_timeout;
endmodule

// File: tb/tb_decode_operand_forward_unit.sv
// Scoreboard bench: each driven cycle pushes hand-derived expected outputs, which are
// popped and compared against the DUT mid-cycle.
module tb_decode_operand_forward_unit;
    localparam logic [7:0] NOP = 8'd0, LW = 8'd1, ADD = 8'd3, SUB = 8'd4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_operand_forward_unit_if #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .NUM_READ_PORTS(2), .OPCODE_WIDTH(8)
    ) bus ();

    decode_operand_forward_unit #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .NUM_READ_PORTS(2), .OPCODE_WIDTH(8),
        .ZERO_REG(1'b1), .TIMEOUT_CYCLES(15)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [3:0]  sel;
        logic        stall;
        logic        timeout;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] rd0, input logic [31:0] rd1,
                              input logic [3:0] sel, input logic stall, input logic timeout);
        exp_t e;
        e.tag = tag; e.rd0 = rd0; e.rd1 = rd1; e.sel = sel; e.stall = stall; e.timeout = timeout;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".rd0"},     bus.o_rd[31:0],          e.rd0);
        check({e.tag, ".rd1"},     bus.o_rd[63:32],         e.rd1);
        check({e.tag, ".sel"},     {28'd0, bus.o_fwd_sel},  {28'd0, e.sel});
        check({e.tag, ".stall"},   {31'd0, bus.o_stall},    {31'd0, e.stall});
        check({e.tag, ".timeout"}, {31'd0, bus.o_timeout},  {31'd0, e.timeout});
    endtask

    // Inputs are already set; sample on the falling edge, then advance past the next rise.
    task automatic step(input string tag, input logic [31:0] rd0, input logic [31:0] rd1,
                        input logic [3:0] sel, input logic stall, input logic timeout);
        expect_out(tag, rd0, rd1, sel, stall, timeout);
        @(negedge clk);
        compare_front();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.i_flush          = 1'b0;
        bus.i_rs             = {4'd2, 4'd1};
        bus.i_rs_used        = 2'b11;
        bus.i_rd             = {32'h0000_BBBB, 32'h0000_AAAA};
        bus.i_execute_opcode = NOP; bus.i_execute_ws = '0; bus.i_execute_data = '0;
        bus.i_memory_opcode  = NOP; bus.i_memory_ws  = '0; bus.i_memory_data  = '0;
        bus.i_memory_valid   = 1'b0;
        bus.i_writeback_we   = 1'b0; bus.i_writeback_ws = '0; bus.i_writeback_data = '0;
    endtask

    task automatic load_hazard_rs5();
        set_idle();
        bus.i_rs[3:0] = 4'd5;
        bus.i_execute_opcode = LW; bus.i_execute_ws = 4'd5; bus.i_execute_data = 32'h99;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        step("reset", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b0, 1'b0);

        // Execute beats memory; writeback reaches port 1.
        set_idle();
        bus.i_rs = {4'd2, 4'd3};
        bus.i_execute_opcode = ADD; bus.i_execute_ws = 4'd3; bus.i_execute_data = 32'h11;
        bus.i_memory_opcode  = ADD; bus.i_memory_ws  = 4'd3; bus.i_memory_data  = 32'h22;
        bus.i_writeback_we = 1'b1; bus.i_writeback_ws = 4'd2; bus.i_writeback_data = 32'h33;
        step("fwd_exe", 32'h11, 32'h33, 4'b1101, 1'b0, 1'b0);

        set_idle();
        bus.i_rs[3:0] = 4'd4;
        bus.i_memory_opcode = SUB; bus.i_memory_ws = 4'd4; bus.i_memory_data = 32'h44;
        bus.i_writeback_we = 1'b1; bus.i_writeback_ws = 4'd4; bus.i_writeback_data = 32'h55;
        step("fwd_mem", 32'h44, 32'hBBBB, 4'b0010, 1'b0, 1'b0);

        set_idle();
        bus.i_rs[3:0] = 4'd6;
        bus.i_memory_opcode = LW; bus.i_memory_ws = 4'd6; bus.i_memory_data = 32'h66;
        bus.i_writeback_we = 1'b1; bus.i_writeback_ws = 4'd6; bus.i_writeback_data = 32'h77;
        step("lw_novalid", 32'h77, 32'hBBBB, 4'b0011, 1'b0, 1'b0);

        // One-cycle load-use stall.
        load_hazard_rs5();
        step("lu_hazard", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b1, 1'b0);
        set_idle();
        bus.i_rs[3:0] = 4'd5;
        bus.i_memory_opcode = LW; bus.i_memory_ws = 4'd5; bus.i_memory_valid = 1'b1;
        bus.i_memory_data = 32'hCAFE;
        step("lu_release", 32'hCAFE, 32'hBBBB, 4'b0010, 1'b0, 1'b0);
        set_idle();
        bus.i_rs[3:0] = 4'd5;
        step("lu_idle", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b0, 1'b0);

        // Valid late by three cycles.
        load_hazard_rs5();
        step("late_hazard", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b1, 1'b0);
        set_idle();
        bus.i_rs[3:0] = 4'd5;
        bus.i_memory_opcode = LW; bus.i_memory_ws = 4'd5; bus.i_memory_data = 32'hDEAD;
        for (int i = 0; i < 3; i++) step("late_wait", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b1, 1'b0);
        bus.i_memory_valid = 1'b1; bus.i_memory_data = 32'hBEEF;
        step("late_release", 32'hBEEF, 32'hBBBB, 4'b0010, 1'b0, 1'b0);
        set_idle();
        step("late_idle", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b0, 1'b0);

        // Load data never arrives: 1 + 15 stall cycles, then abort.
        load_hazard_rs5();
        step("to_hazard", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b1, 1'b0);
        set_idle();
        bus.i_rs[3:0] = 4'd5;
        for (int i = 0; i < 15; i++) step("to_wait", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b1, 1'b0);
        step("to_abort", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b0, 1'b0);
        step("to_sticky", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b0, 1'b1);

        // Zero register and unused port.
        set_idle();
        bus.i_rs[3:0] = 4'd0;
        bus.i_execute_opcode = LW; bus.i_execute_ws = 4'd0;
        bus.i_writeback_we = 1'b1; bus.i_writeback_ws = 4'd0; bus.i_writeback_data = 32'h7;
        step("zero_reg", 32'h0, 32'hBBBB, 4'b0000, 1'b0, 1'b1);
        set_idle();
        bus.i_rs[7:4] = 4'd9; bus.i_rs_used = 2'b01;
        bus.i_execute_opcode = LW; bus.i_execute_ws = 4'd9;
        step("unused_port", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b0, 1'b1);

        // Flush inside WAIT_LOAD.
        load_hazard_rs5();
        step("fl_hazard", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b1, 1'b1);
        set_idle();
        bus.i_rs[3:0] = 4'd5;
        step("fl_wait", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b1, 1'b1);
        bus.i_flush = 1'b1;
        step("fl_flush", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b0, 1'b1);
        bus.i_flush = 1'b0;
        step("fl_idle", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a stall, no clock edge in between.
        load_hazard_rs5();
        step("rs_hazard", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b1, 1'b1);
        set_idle();
        bus.i_rs[3:0] = 4'd5;
        expect_out("rs_wait", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b1, 1'b1);
        #1 compare_front();
        rst_n = 1'b0;
        expect_out("rs_async", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b0, 1'b0);
        #1 compare_front();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("rs_after", 32'hAAAA, 32'hBBBB, 4'b0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
